// File: rtl/drm_pkg.sv
// Shared widths, per-user config record and FSM encoding for the read-out scheduler.
package drm_pkg;
  localparam int N_USER    = 8;
  localparam int CB_W      = 8;
  localparam int SZ_W      = 16;
  localparam int ST_W      = 14;
  localparam int ST_STRIDE = 16;
  localparam int WORD_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CB_SETUP,
    S_READ,
    S_NEXT_USER,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CB_W-1:0] cb_num;
    logic [CB_W-1:0] e0_cb_num;
    logic [SZ_W-1:0] e0_sz;
    logic [SZ_W-1:0] e1_sz;
    logic [ST_W-1:0] start;
  } user_cfg_t;

  function automatic logic [3:0] clamp_users(input logic [3:0] n, input int max_n);
    return (int'(n) > max_n) ? 4'(max_n) : n;
  endfunction
endpackage

// File: rtl/drm_cfg_slice.sv
// Picks one user's configuration fields out of the packed per-user buses.
module drm_cfg_slice
  import drm_pkg::*;
#(
  parameter int N = N_USER
) (
  input  logic [3:0]             idx,
  input  logic [N*CB_W-1:0]      cb_num_bus,
  input  logic [N*CB_W-1:0]      e0_cb_num_bus,
  input  logic [N*SZ_W-1:0]      e0_sz_bus,
  input  logic [N*SZ_W-1:0]      e1_sz_bus,
  input  logic [N*ST_STRIDE-1:0] start_bus,
  output user_cfg_t              cfg
);
  // an index past the last user reads back as an empty user
  always_comb begin
    cfg = '0;
    if (int'(idx) < N) begin
      cfg.cb_num    = cb_num_bus[int'(idx)*CB_W +: CB_W];
      cfg.e0_cb_num = e0_cb_num_bus[int'(idx)*CB_W +: CB_W];
      cfg.e0_sz     = e0_sz_bus[int'(idx)*SZ_W +: SZ_W];
      cfg.e1_sz     = e1_sz_bus[int'(idx)*SZ_W +: SZ_W];
      cfg.start     = start_bus[int'(idx)*ST_STRIDE +: ST_W];
    end
  end
endmodule

// File: rtl/drm_rd_sched.sv
// Walks users and code blocks of a finished slot, issuing input-buffer reads with
// downstream back-pressure and tagging each returned word.
module drm_rd_sched #(
  parameter int N_USER = 8,
  parameter int AW     = 11
) (
  input  logic                                  i_core_clk,
  input  logic                                  i_rx_rstn,
  input  logic                                  i_rdm_slot_end,
  input  logic                                  i_rd_bank,
  input  logic [3:0]                            i_user_num,
  input  logic [N_USER*drm_pkg::CB_W-1:0]       i_users_cb_num,
  input  logic [N_USER*drm_pkg::CB_W-1:0]       i_users_e0_cb_num,
  input  logic [N_USER*drm_pkg::SZ_W-1:0]       i_users_e0_sz,
  input  logic [N_USER*drm_pkg::SZ_W-1:0]       i_users_e1_sz,
  input  logic [N_USER*drm_pkg::ST_STRIDE-1:0]  i_users_input_buffer_start,
  input  logic                                  i_dn_ready,
  output logic                                  o_rd_en,
  output logic [AW-1:0]                         o_rd_addr,
  output logic                                  o_rd_vld,
  output logic [3:0]                            o_user_idx,
  output logic [7:0]                            o_cb_idx,
  output logic                                  o_cb_first,
  output logic                                  o_cb_last,
  output logic                                  o_busy,
  output logic                                  o_done
);
  import drm_pkg::*;

  state_t state_q, state_d;

  logic                          bank_q;
  logic [3:0]                    n_users_q;
  logic [N_USER*CB_W-1:0]        cb_num_q, e0_cb_num_q;
  logic [N_USER*SZ_W-1:0]        e0_sz_q, e1_sz_q;
  logic [N_USER*ST_STRIDE-1:0]   start_q;

  logic [3:0]        user_idx;
  logic [CB_W-1:0]   cb_idx;
  logic [WORD_W-1:0] ptr;
  logic [SZ_W-1:0]   wcnt, cb_len;

  user_cfg_t       ucfg;
  logic [SZ_W-1:0] sel_len;
  logic            more_cb, more_user, last_word, rd_en;

  drm_cfg_slice #(.N(N_USER)) u_cfg_slice (
    .idx           (user_idx),
    .cb_num_bus    (cb_num_q),
    .e0_cb_num_bus (e0_cb_num_q),
    .e0_sz_bus     (e0_sz_q),
    .e1_sz_bus     (e1_sz_q),
    .start_bus     (start_q),
    .cfg           (ucfg)
  );

  assign sel_len   = (cb_idx < ucfg.e0_cb_num) ? ucfg.e0_sz : ucfg.e1_sz;
  assign more_cb   = ({1'b0, cb_idx} + 9'd1) < {1'b0, ucfg.cb_num};
  assign more_user = ({1'b0, user_idx} + 5'd1) < {1'b0, n_users_q};
  assign last_word = (wcnt == cb_len - SZ_W'(1));

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = (state_q == S_READ) && i_dn_ready;
    o_busy  = (state_q != S_IDLE);
    o_done  = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE:
        if (i_rdm_slot_end)
          state_d = (clamp_users(i_user_num, N_USER) == 4'd0) ? S_DONE : S_LOAD;
      S_LOAD:      state_d = (ucfg.cb_num == '0) ? S_NEXT_USER : S_CB_SETUP;
      S_CB_SETUP:
        if (sel_len != '0) state_d = S_READ;
        else               state_d = more_cb ? S_CB_SETUP : S_NEXT_USER;
      S_READ:
        if (rd_en && last_word) state_d = more_cb ? S_CB_SETUP : S_NEXT_USER;
      S_NEXT_USER: state_d = more_user ? S_LOAD : S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign o_rd_en   = rd_en;
  assign o_rd_addr = AW'({bank_q, ptr});

  // configuration is captured only on an accepted start, so later bus changes are inert
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      bank_q      <= 1'b0;
      n_users_q   <= '0;
      cb_num_q    <= '0;
      e0_cb_num_q <= '0;
      e0_sz_q     <= '0;
      e1_sz_q     <= '0;
      start_q     <= '0;
      user_idx    <= '0;
      cb_idx      <= '0;
      ptr         <= '0;
      wcnt        <= '0;
      cb_len      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (i_rdm_slot_end) begin
            bank_q      <= i_rd_bank;
            n_users_q   <= clamp_users(i_user_num, N_USER);
            cb_num_q    <= i_users_cb_num;
            e0_cb_num_q <= i_users_e0_cb_num;
            e0_sz_q     <= i_users_e0_sz;
            e1_sz_q     <= i_users_e1_sz;
            start_q     <= i_users_input_buffer_start;
            user_idx    <= '0;
          end
        S_LOAD: begin
          ptr    <= ucfg.start[ST_W-1:4];
          cb_idx <= '0;
        end
        S_CB_SETUP: begin
          cb_len <= sel_len;
          wcnt   <= '0;
          if (sel_len == '0) cb_idx <= cb_idx + 8'd1;
        end
        S_READ:
          if (rd_en) begin
            ptr  <= ptr + WORD_W'(1);
            wcnt <= wcnt + SZ_W'(1);
            if (last_word) cb_idx <= cb_idx + 8'd1;
          end
        S_NEXT_USER: user_idx <= user_idx + 4'd1;
        default: ;
      endcase
    end
  end

  // read data returns one cycle after the strobe; tags follow it
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      o_rd_vld   <= 1'b0;
      o_user_idx <= '0;
      o_cb_idx   <= '0;
      o_cb_first <= 1'b0;
      o_cb_last  <= 1'b0;
    end else begin
      o_rd_vld   <= rd_en;
      o_cb_first <= rd_en && (wcnt == '0);
      o_cb_last  <= rd_en && last_word;
      if (rd_en) begin
        o_user_idx <= user_idx;
        o_cb_idx   <= cb_idx;
      end
    end
  end
endmodule

// File: tb/tb_drm_rd_sched.sv
// Directed bench: a per-slot read list is built from the config rules and checked
// against every strobe and every returned tag, plus literal address/tag expectations.
module tb_drm_rd_sched;
  typedef struct {
    logic [10:0] addr;
    logic [3:0]  u;
    logic [7:0]  c;
    logic        f;
    logic        l;
  } rd_t;

  logic clk = 1'b0, rstn = 1'b0, slot_end = 1'b0, rd_bank = 1'b0, dn_ready = 1'b0;
  logic [3:0]   user_num = '0;
  logic [63:0]  cb_bus = '0, e0cb_bus = '0;
  logic [127:0] e0s_bus = '0, e1s_bus = '0, st_bus = '0;

  logic        rd_en, rd_vld, cf, cl, busy, done;
  logic [10:0] rd_addr;
  logic [3:0]  uo;
  logic [7:0]  co;

  drm_rd_sched #(.N_USER(8), .AW(11)) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_rdm_slot_end(slot_end), .i_rd_bank(rd_bank),
    .i_user_num(user_num), .i_users_cb_num(cb_bus), .i_users_e0_cb_num(e0cb_bus),
    .i_users_e0_sz(e0s_bus), .i_users_e1_sz(e1s_bus), .i_users_input_buffer_start(st_bus),
    .i_dn_ready(dn_ready), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_rd_vld(rd_vld),
    .o_user_idx(uo), .o_cb_idx(co), .o_cb_first(cf), .o_cb_last(cl),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int c_cb[8], c_e0cb[8], c_e0s[8], c_e1s[8], c_st[8];
  int c_un;
  bit c_bank;

  rd_t exq[$];
  logic [10:0] la[$];
  logic [3:0]  lu[$];
  logic [7:0]  lc[$];
  logic        ll[$];
  int ai, vi, done_cnt;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int u = 0; u < 8; u++) begin
      c_cb[u] = 0; c_e0cb[u] = 0; c_e0s[u] = 0; c_e1s[u] = 0; c_st[u] = 0;
    end
    c_un = 0; c_bank = 1'b0;
  endtask

  task automatic apply_cfg();
    for (int u = 0; u < 8; u++) begin
      cb_bus[8*u +: 8]    = 8'(c_cb[u]);
      e0cb_bus[8*u +: 8]  = 8'(c_e0cb[u]);
      e0s_bus[16*u +: 16] = 16'(c_e0s[u]);
      e1s_bus[16*u +: 16] = 16'(c_e1s[u]);
      st_bus[16*u +: 16]  = 16'(c_st[u]);
    end
    user_num = 4'(c_un);
    rd_bank  = c_bank;
  endtask

  // every read the slot must produce, in order, from the config rules
  task automatic build_model();
    int n, p, len;
    rd_t e;
    exq.delete();
    n = (c_un > 8) ? 8 : c_un;
    for (int u = 0; u < n; u++) begin
      p = (c_st[u] & 16'h3FFF) >> 4;
      for (int c = 0; c < c_cb[u]; c++) begin
        len = (c < c_e0cb[u]) ? c_e0s[u] : c_e1s[u];
        for (int w = 0; w < len; w++) begin
          e.addr = 11'((c_bank ? 1024 : 0) + (p % 1024));
          e.u = 4'(u); e.c = 8'(c); e.f = (w == 0); e.l = (w == len - 1);
          exq.push_back(e);
          p++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rd_en) begin
        if (ai < exq.size()) chk("rd_addr", rd_addr, exq[ai].addr);
        la.push_back(rd_addr);
        ai++;
      end
      if (rd_vld) begin
        if (vi < exq.size()) begin
          chk("tag_user", uo, exq[vi].u);
          chk("tag_cb", co, exq[vi].c);
          chk("tag_first", cf, exq[vi].f);
          chk("tag_last", cl, exq[vi].l);
        end
        lu.push_back(uo); lc.push_back(co); ll.push_back(cl);
        vi++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_slot(input string tag, input int mode, input bit dup);
    bit seen;
    build_model();
    apply_cfg();
    la.delete(); lu.delete(); lc.delete(); ll.delete();
    ai = 0; vi = 0; done_cnt = 0; seen = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1 slot_end = 1'b1;
    @(posedge clk); #1 slot_end = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      case (mode)
        0:       dn_ready = 1'b1;
        1:       dn_ready = (cyc % 2 == 0);
        default: dn_ready = 1'($urandom_range(0, 1));
      endcase
      if (dup && cyc == 3) begin
        slot_end = 1'b1;
        st_bus   = ~st_bus;
        cb_bus   = cb_bus ^ 64'h0303_0303_0303_0303;
      end
      if (dup && cyc == 4) slot_end = 1'b0;
      @(negedge clk);
      if (cyc == 0) chk({tag, ":busy_rise"}, busy, 1);
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({tag, ":done_seen"}, seen, 1);
    @(posedge clk); #1;
    slot_end = 1'b0; dn_ready = 1'b0;
    apply_cfg();
    @(negedge clk);
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":busy_fall"}, busy, 0);
    chk({tag, ":rd_en_count"}, ai, exq.size());
    chk({tag, ":vld_count"}, vi, exq.size());
    chk({tag, ":done_count"}, done_cnt, 1);
    chk_en = 1'b0;
  endtask

  initial begin
    int dc, n1;
    int e37[5];
    e37 = '{11'h404, 11'h405, 11'h406, 11'h407, 11'h408};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst:rd_en", rd_en, 0);
    chk("rst:rd_vld", rd_vld, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:addr", rd_addr, 0);
    chk("rst:tags", {uo, co, cf, cl}, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // one user, two CBs of sizes 3 then 2, bank 1
    clear_cfg();
    c_un = 1; c_bank = 1'b1; c_cb[0] = 2; c_e0cb[0] = 1; c_e0s[0] = 3; c_e1s[0] = 2; c_st[0] = 16'h0040;
    run_slot("basic", 0, 1'b0);
    for (int k = 0; k < 5; k++) chk($sformatf("basic:addr%0d", k), la[k], e37[k]);
    chk("basic:last_flags", {ll[4], ll[3], ll[2], ll[1], ll[0]}, 5'b10100);

    // same slot with a second start and scrambled config while busy
    run_slot("dup_start", 0, 1'b1);
    chk("dup_start:addr0", la[0], 11'h404);

    // ready toggling during a 4-word CB
    clear_cfg();
    c_un = 1; c_cb[0] = 1; c_e0cb[0] = 1; c_e0s[0] = 4; c_st[0] = 16'h0200;
    run_slot("toggle", 1, 1'b0);
    chk("toggle:reads", la.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("toggle:addr%0d", k), la[k], 11'h020 + k);

    // pointer wrap inside the bank
    clear_cfg();
    c_un = 1; c_bank = 1'b1; c_cb[0] = 1; c_e0cb[0] = 1; c_e0s[0] = 3; c_st[0] = 16'h3FF0;
    run_slot("wrap", 0, 1'b0);
    chk("wrap:a0", la[0], 11'h7FF);
    chk("wrap:a1", la[1], 11'h400);
    chk("wrap:a2", la[2], 11'h401);

    // skipped user and empty CBs
    clear_cfg();
    c_un = 3;
    c_cb[0] = 1; c_e0cb[0] = 1; c_e0s[0] = 2; c_st[0] = 16'h0100;
    c_cb[1] = 0; c_e0s[1] = 5; c_st[1] = 16'h0200;
    c_cb[2] = 3; c_e0cb[2] = 2; c_e0s[2] = 0; c_e1s[2] = 2; c_st[2] = 16'h0300;
    run_slot("skip", 2, 1'b0);
    n1 = 0;
    foreach (lu[k]) if (lu[k] == 4'd1) n1++;
    chk("skip:user1_words", n1, 0);
    chk("skip:users", {lu[0], lu[1], lu[2], lu[3]}, 16'h0022);
    chk("skip:cb_of_user2", {lc[2], lc[3]}, 16'h0202);
    chk("skip:addr_u2", la[2], 11'h030);

    // user count clamped to 8
    clear_cfg();
    c_un = 9;
    for (int u = 0; u < 8; u++) begin c_cb[u] = 1; c_e1s[u] = 1; c_st[u] = u << 4; end
    run_slot("clamp", 2, 1'b0);
    chk("clamp:reads", la.size(), 8);

    // zero users
    clear_cfg();
    c_un = 0; c_cb[0] = 1; c_e0cb[0] = 1; c_e0s[0] = 3;
    run_slot("zero_users", 0, 1'b0);
    chk("zero_users:reads", la.size(), 0);

    // multi-user, mixed sizes, random back-pressure
    clear_cfg();
    c_un = 2; c_bank = 1'b1;
    c_cb[0] = 3; c_e0cb[0] = 2; c_e0s[0] = 2; c_e1s[0] = 3; c_st[0] = 16'h1230;
    c_cb[1] = 2; c_e0cb[1] = 0; c_e0s[1] = 9; c_e1s[1] = 4; c_st[1] = 16'h0FF5;
    run_slot("mixed", 2, 1'b0);

    // reset in the middle of a long CB
    clear_cfg();
    c_un = 1; c_cb[0] = 1; c_e0cb[0] = 1; c_e0s[0] = 40; c_st[0] = 16'h0500;
    apply_cfg();
    dn_ready = 1'b1;
    @(posedge clk); #1 slot_end = 1'b1;
    @(posedge clk); #1 slot_end = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_mid:in_read", rd_en, 1);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid:rd_en", rd_en, 0);
    chk("rst_mid:rd_vld", rd_vld, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:addr", rd_addr, 0);
    chk("rst_mid:tags", {uo, co, cf, cl}, 0);
    dc = 0;
    repeat (3) begin @(negedge clk); dc += int'(done); end
    @(posedge clk); #1 rstn = 1'b1; dn_ready = 1'b0;
    repeat (4) begin @(negedge clk); dc += int'(done); end
    chk("rst_mid:no_done", dc, 0);
    chk("rst_mid:idle", busy, 0);

    c_e0s[0] = 3; c_st[0] = 16'h0100;
    run_slot("after_rst", 0, 1'b0);
    chk("after_rst:addr0", la[0], 11'h010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
